// File: rtl/pp_compress_if.sv
// pp_compress_if: operand/result valid-ready bus for the partial-product compressor pipe
interface pp_compress_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pp;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  modport master (output in_valid, pp, out_ready, input in_ready, out_valid, prod);
  modport slave  (input in_valid, pp, out_ready, output in_ready, out_valid, prod);
endinterface

// File: rtl/pp_compress_pipe.sv
// pp_compress_pipe: 3-stage 4:2 compressor tree + CPA with OR-approximated low columns
module pp_compress_pipe #(
  parameter int APPROX_COLS = 0
) (
  input logic        clk,
  input logic        rst,
  pp_compress_if.slave bus
);
  localparam logic [15:0] AMASK = 16'((32'd1 << APPROX_COLS) - 32'd1);
  // returns {carry, sum}; the carry row still has to be shifted left by one
  function automatic logic [31:0] c42(input logic [15:0] w, x, y, z);
    logic [15:0] s, cy;
    logic c, t;
    c = 1'b0;
    s = '0;
    cy = '0;
    for (int k = 0; k < 16; k++) begin
      t = w[k] ^ x[k] ^ y[k];
      s[k] = t ^ z[k] ^ c;
      cy[k] = (t & z[k]) | (t & c) | (z[k] & c);
      c = (w[k] & x[k]) | (w[k] & y[k]) | (x[k] & y[k]);
    end
    return {cy, s};
  endfunction
  logic [15:0] row [8];
  logic [15:0] orr;
  logic [31:0] g0, g1, h;
  logic [15:0] r1 [4];
  logic [15:0] r2 [2];
  logic [15:0] a1, a2, prod_q;
  logic        v1, v2, v3, adv1, adv2, adv3;
  always_comb begin
    logic [15:0] raw;
    orr = '0;
    for (int j = 0; j < 8; j++) begin
      raw = 16'(bus.pp[8*j +: 8]) << j;
      orr = orr | raw;
      row[j] = raw & ~AMASK;
    end
  end
  assign g0 = c42(row[0], row[1], row[2], row[3]);
  assign g1 = c42(row[4], row[5], row[6], row[7]);
  assign h  = c42(r1[0], r1[1], r1[2], r1[3]);
  assign adv3 = bus.out_ready | !v3;
  assign adv2 = adv3 | !v2;
  assign adv1 = adv2 | !v1;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.prod      = prod_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3} <= '0;
      r1 <= '{default: '0};
      r2 <= '{default: '0};
      {a1, a2, prod_q} <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (adv1 && bus.in_valid) begin
        r1[0] <= g0[15:0];
        r1[1] <= g0[31:16] << 1;
        r1[2] <= g1[15:0];
        r1[3] <= g1[31:16] << 1;
        a1 <= orr & AMASK;
      end
      if (adv2) begin
        v2 <= v1;
        r2[0] <= h[15:0];
        r2[1] <= h[31:16] << 1;
        a2 <= a1;
      end
      // exact rows are zero in approximated columns, so OR-ing the approx field is carry-free
      if (adv3) begin
        v3 <= v2;
        prod_q <= (r2[0] + r2[1]) | a2;
      end
    end
  end
endmodule

// File: tb/tb_pp_compress_pipe.sv
// tb_pp_compress_pipe: directed and streamed checks of the compressor pipe for APPROX_COLS 0/4/8
module tb_pp_compress_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pp_compress_if b0 ();
  pp_compress_if b4 ();
  pp_compress_if b8 ();
  pp_compress_pipe #(.APPROX_COLS(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  pp_compress_pipe #(.APPROX_COLS(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  pp_compress_pipe #(.APPROX_COLS(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  int nvec = 0;
  int nerr = 0;

  function automatic logic [63:0] ppgen(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] p;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        p[8*j+i] = a[i] & b[j];
    return p;
  endfunction

  function automatic logic [15:0] model(input logic [63:0] p, input int ac);
    logic [15:0] e, ab;
    e = '0;
    ab = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (i + j >= ac) e = e + (16'(p[8*j+i]) << (i + j));
        else ab[i+j] = ab[i+j] | p[8*j+i];
    return e + ab;
  endfunction

  task automatic drive(input logic v, input logic [63:0] p, input logic r);
    b0.in_valid = v; b4.in_valid = v; b8.in_valid = v;
    b0.pp = p; b4.pp = p; b8.pp = p;
    b0.out_ready = r; b4.out_ready = r; b8.out_ready = r;
  endtask

  task automatic test_reset;
    @(negedge clk);
    nvec++;
    if ({b0.out_valid, b0.prod, b0.in_ready} !== {1'b0, 16'h0000, 1'b1}) begin
      nerr++; $display("FAIL reset_held ov/prod/rdy=%b/%h/%b exp 0/0000/1", b0.out_valid, b0.prod, b0.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({b0.out_valid, b0.prod, b0.in_ready} !== {1'b0, 16'h0000, 1'b1}) begin
      nerr++; $display("FAIL reset_released ov/prod/rdy=%b/%h/%b exp 0/0000/1", b0.out_valid, b0.prod, b0.in_ready);
    end
  endtask

  task automatic test_exact;
    @(negedge clk);
    drive(1'b1, '1, 1'b1);
    nvec++;
    if (b0.in_ready !== 1'b1) begin nerr++; $display("FAIL exact_in_ready got %b exp 1", b0.in_ready); end
    @(negedge clk);
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if (c < 2 && b0.out_valid !== 1'b0) begin nerr++; $display("FAIL exact_early cyc%0d out_valid=%b exp 0", c, b0.out_valid); end
      if (c == 2 && {b0.out_valid, b0.prod} !== {1'b1, 16'hFE01}) begin
        nerr++; $display("FAIL exact_ones ov/prod=%b/%h exp 1/fe01", b0.out_valid, b0.prod);
      end
      if (c < 2) @(negedge clk);
    end
    @(negedge clk);
    nvec++;
    if (b0.out_valid !== 1'b0) begin nerr++; $display("FAIL exact_drained out_valid=%b exp 0", b0.out_valid); end
  endtask

  task automatic test_stream;
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    logic [15:0] exp_p [3];
    a = '{8'h0D, 8'h00, 8'h80};
    b = '{8'h0B, 8'h5A, 8'h80};
    exp_p = '{16'h008F, 16'h0000, 16'h4000};
    @(negedge clk);
    drive(1'b1, ppgen(a[0], b[0]), 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nvec++;
      if (c >= 2 && c <= 4) begin
        if ({b0.out_valid, b0.prod} !== {1'b1, exp_p[c-2]}) begin
          nerr++; $display("FAIL stream_%0d ov/prod=%b/%h exp 1/%h", c - 2, b0.out_valid, b0.prod, exp_p[c-2]);
        end
      end else if (b0.out_valid !== 1'b0) begin
        nerr++; $display("FAIL stream_gap cyc%0d out_valid=%b exp 0", c, b0.out_valid);
      end
      if (c < 2) drive(1'b1, ppgen(a[c+1], b[c+1]), 1'b1);
      else drive(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]  a [5];
    logic [7:0]  b [5];
    logic [15:0] exp_p [3];
    a = '{8'h12, 8'hFF, 8'h10, 8'h77, 8'h55};
    b = '{8'h34, 8'h01, 8'h10, 8'h22, 8'h33};
    exp_p = '{16'h03A8, 16'h00FF, 16'h0100};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, ppgen(a[c], b[c]), 1'b0);
      #1;
      nvec++;
      if (b0.in_ready !== (c < 3)) begin
        nerr++; $display("FAIL bp_offer_%0d in_ready=%b exp %b", c, b0.in_ready, c < 3);
      end
      if (c >= 3 && {b0.out_valid, b0.prod} !== {1'b1, exp_p[0]}) begin
        nerr++; $display("FAIL bp_hold_%0d ov/prod=%b/%h exp 1/%h", c, b0.out_valid, b0.prod, exp_p[0]);
      end
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b1);
    #1;
    nvec++;
    if (b0.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_drain_ready in_ready=%b exp 1", b0.in_ready); end
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (c < 3 && {b0.out_valid, b0.prod} !== {1'b1, exp_p[c]}) begin
        nerr++; $display("FAIL bp_drain_%0d ov/prod=%b/%h exp 1/%h", c, b0.out_valid, b0.prod, exp_p[c]);
      end
      if (c == 3 && b0.out_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty out_valid=%b exp 0", b0.out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_approx;
    @(negedge clk);
    drive(1'b1, '1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({b4.out_valid, b4.prod} !== {1'b1, 16'hFDDF}) begin
      nerr++; $display("FAIL approx4 ov/prod=%b/%h exp 1/fddf", b4.out_valid, b4.prod);
    end
    nvec++;
    if ({b8.out_valid, b8.prod} !== {1'b1, 16'hF7FF}) begin
      nerr++; $display("FAIL approx8 ov/prod=%b/%h exp 1/f7ff", b8.out_valid, b8.prod);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, ppgen(8'hAB, 8'hCD), 1'b1);
    @(negedge clk);
    drive(1'b1, ppgen(8'h11, 8'h22), 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 1'b1);
    rst = 1'b1;
    #1;
    nvec++;
    if ({b0.out_valid, b0.prod} !== {1'b0, 16'h0000}) begin
      nerr++; $display("FAIL rstmid_async ov/prod=%b/%h exp 0/0000", b0.out_valid, b0.prod);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, ppgen(8'h03, 8'h05), 1'b1);
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if ({b0.out_valid, b0.prod} !== {1'b0, 16'h0000}) begin
        nerr++; $display("FAIL rstmid_quiet cyc%0d ov/prod=%b/%h exp 0/0000", c, b0.out_valid, b0.prod);
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b1);
    end
    nvec++;
    if ({b0.out_valid, b0.prod} !== {1'b1, 16'h000F}) begin
      nerr++; $display("FAIL rstmid_next ov/prod=%b/%h exp 1/000f", b0.out_valid, b0.prod);
    end
  endtask

  task automatic test_random;
    logic [15:0] q0 [$];
    logic [15:0] q4 [$];
    logic [15:0] q8 [$];
    logic [15:0] e0, e4, e8;
    int pushed, popped;
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 620; c++) begin
      @(negedge clk);
      if (c < 600) drive($urandom_range(0, 3) != 0, ppgen(8'($urandom), 8'($urandom)), $urandom_range(0, 3) != 0);
      else drive(1'b0, '0, 1'b1);
      #1;
      if (b0.in_valid && b0.in_ready) begin
        q0.push_back(model(b0.pp, 0));
        q4.push_back(model(b0.pp, 4));
        q8.push_back(model(b0.pp, 8));
        pushed++;
      end
      if (b0.out_valid && b0.out_ready) begin
        nvec++;
        if (q0.size() == 0) begin
          nerr++; $display("FAIL rand_extra prod=%h with no pending input", b0.prod);
        end else begin
          e0 = q0.pop_front(); e4 = q4.pop_front(); e8 = q8.pop_front();
          popped++;
          if ({b0.prod, b4.prod, b8.prod} !== {e0, e4, e8}) begin
            nerr++; $display("FAIL rand_%0d prod0/4/8=%h/%h/%h exp %h/%h/%h", popped, b0.prod, b4.prod, b8.prod, e0, e4, e8);
          end
        end
      end
    end
    nvec++;
    if (popped != pushed) begin nerr++; $display("FAIL rand_count results=%0d exp %0d", popped, pushed); end
  endtask

  initial begin
    drive(1'b0, '0, 1'b1);
    test_reset;
    test_exact;
    test_stream;
    test_backpressure;
    test_approx;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
